// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-buffered UART transmitter: register map,
// CTRL field layout and shifter state encodings.
package uart_tx_fifo_pkg;

  localparam logic [7:0] ADR_STAT = 8'h00;
  localparam logic [7:0] ADR_CTRL = 8'h08;
  localparam logic [7:0] ADR_DATA = 8'h10;

  // CTRL layout, MSB first: [21] tx_en, [20] two_stop, [19] odd, [18] par_en,
  // [17:16] data bits minus 5, [15:0] divisor
  typedef struct packed {
    logic        tx_en;
    logic        two_stop;
    logic        odd;
    logic        par_en;
    logic [1:0]  dbits;
    logic [15:0] div;
  } ctrl_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Selects the low 5..8 bits that take part in a frame
  function automatic logic [7:0] data_mask(input logic [1:0] dbits);
    return 8'hFF >> (2'd3 - dbits);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty/level flags; a write while full is
// dropped unless a read happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [LW-1:0]    count_q;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rptr_q];
  assign level   = count_q;

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem[wptr_q] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + AW'(1);
      if (do_rd) rptr_q <= rptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Wishbone-style register front end, TX FIFO and UART serializer with
// configurable divisor, data bits, parity and stop bits.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DAT_WIDTH  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           uart_adr_i,
  input  logic [DAT_WIDTH-1:0] uart_dat_i,
  output logic [DAT_WIDTH-1:0] uart_dat_o,
  input  logic                 uart_we_i,
  input  logic                 uart_stb_i,
  output logic                 uart_ack_o,
  output logic                 uart_err_o,
  output logic                 uart_tx,
  output logic                 tx_empty_o
);

  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CTRL_W  = $bits(ctrl_t);
  localparam logic [15:0] RST_DIV = 16'(CLK_HZ / BAUD);
  localparam ctrl_t CTRL_RST = '{tx_en: 1'b1, two_stop: 1'b0, odd: 1'b0,
                                 par_en: 1'b0, dbits: 2'd3, div: RST_DIV};

  ctrl_t                ctrl_q;
  ctrl_t                fmt_q;
  ctrl_t                fmt_d;
  logic                 stb_q;
  logic                 ack_q;
  logic                 err_q;
  logic [DAT_WIDTH-1:0] dat_q;
  logic                 access;
  logic                 acc_ack;
  logic                 acc_err;
  logic                 push;
  logic                 ctrl_we;
  logic [DAT_WIDTH-1:0] rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LVL_W-1:0]     fifo_level;
  logic [7:0]           fifo_rdata;
  logic [7:0]           level8;
  logic [15:0]          stat;
  logic                 pop;
  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic [15:0]          cnt_q;
  logic [15:0]          cnt_d;
  logic [15:0]          div_m1;
  logic [2:0]           bit_q;
  logic [2:0]           bit_d;
  logic [7:0]           shreg_q;
  logic [7:0]           shreg_d;
  logic                 par_q;
  logic                 par_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 tick;
  logic                 last_data;
  logic                 start_frame;
  logic                 unused_bits;

  assign unused_bits = ^{uart_dat_i[DAT_WIDTH-1:CTRL_W], fmt_q.tx_en};

  // Bus access happens once, on the first cycle stb is seen high
  assign access = uart_stb_i & ~stb_q;
  assign level8 = (32'(fifo_level) > 32'd255) ? 8'hFF : 8'(fifo_level);
  assign stat   = {level8, 5'b0, fifo_empty, fifo_full,
                   ~fifo_empty | (state_q != ST_IDLE)};

  always_comb begin
    acc_ack = 1'b0;
    acc_err = 1'b0;
    push    = 1'b0;
    ctrl_we = 1'b0;
    rdata   = '0;
    case (uart_adr_i)
      ADR_STAT: begin
        acc_ack = 1'b1;
        if (!uart_we_i) rdata = DAT_WIDTH'(stat);
      end
      ADR_CTRL: begin
        acc_ack = 1'b1;
        if (uart_we_i) ctrl_we = 1'b1;
        else           rdata   = DAT_WIDTH'(ctrl_q);
      end
      ADR_DATA: begin
        if (uart_we_i && fifo_full && !pop) begin
          acc_err = 1'b1;
        end else begin
          acc_ack = 1'b1;
          push    = uart_we_i;
        end
      end
      default: acc_err = 1'b1;
    endcase
  end

  // Response registers hold while stb stays high, clear once it drops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stb_q  <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dat_q  <= '0;
      ctrl_q <= CTRL_RST;
    end else begin
      stb_q <= uart_stb_i;
      if (access) begin
        ack_q <= acc_ack;
        err_q <= acc_err;
        dat_q <= rdata;
      end else if (!uart_stb_i) begin
        ack_q <= 1'b0;
        err_q <= 1'b0;
      end
      if (access && ctrl_we) begin
        ctrl_q <= ctrl_t'(uart_dat_i[CTRL_W-1:0]);
      end
    end
  end

  assign uart_ack_o = ack_q & uart_stb_i;
  assign uart_err_o = err_q & uart_stb_i;
  assign uart_dat_o = dat_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_en   (access & push),
    .wr_data (uart_dat_i[7:0]),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Divisors below 2 are clamped so every bit lasts at least two cycles
  assign div_m1    = (fmt_q.div < 16'd2) ? 16'd1 : fmt_q.div - 16'd1;
  assign tick      = (cnt_q == div_m1);
  assign last_data = (bit_q == ({1'b0, fmt_q.dbits} + 3'd4));
  assign pop       = start_frame;

  always_comb begin
    state_d     = state_q;
    cnt_d       = tick ? '0 : cnt_q + 16'd1;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    fmt_d       = fmt_q;
    par_d       = par_q;
    tx_d        = tx_q;
    start_frame = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d       = '0;
        tx_d        = 1'b1;
        start_frame = ctrl_q.tx_en & ~fifo_empty;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shreg_q[0];
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (last_data) begin
            bit_d = '0;
            if (fmt_q.par_en) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (fmt_q.two_stop && (bit_q == 3'd0)) begin
            bit_d = 3'd1;
          end else begin
            state_d     = ST_IDLE;
            tx_d        = 1'b1;
            start_frame = ctrl_q.tx_en & ~fifo_empty;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // A new frame samples the live CTRL so mid-frame writes wait for it
    if (start_frame) begin
      state_d = ST_START;
      cnt_d   = '0;
      tx_d    = 1'b0;
      shreg_d = fifo_rdata;
      fmt_d   = ctrl_q;
      par_d   = (^(fifo_rdata & data_mask(ctrl_q.dbits))) ^ ctrl_q.odd;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      fmt_q   <= CTRL_RST;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      fmt_q   <= fmt_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx    = tx_q;
  assign tx_empty_o = fifo_empty & (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: register map, serial framing, FIFO
// full handling, format changes and asynchronous reset.
module tb_uart_tx_fifo;

  localparam int DIV = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  uart_adr_i = '0;
  logic [63:0] uart_dat_i = '0;
  logic [63:0] uart_dat_o;
  logic        uart_we_i = 1'b0;
  logic        uart_stb_i = 1'b0;
  logic        uart_ack_o;
  logic        uart_err_o;
  logic        uart_tx;
  logic        tx_empty_o;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] rd;
  logic        ack;
  logic        err;
  logic        found;
  logic        samp [0:255];
  logic        emp  [0:255];
  logic        exp_bits [0:127];
  int          nexp;

  uart_tx_fifo #(
    .CLK_HZ     (100_000_000),
    .BAUD       (115200),
    .FIFO_DEPTH (4),
    .DAT_WIDTH  (64)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .uart_adr_i (uart_adr_i),
    .uart_dat_i (uart_dat_i),
    .uart_dat_o (uart_dat_o),
    .uart_we_i  (uart_we_i),
    .uart_stb_i (uart_stb_i),
    .uart_ack_o (uart_ack_o),
    .uart_err_o (uart_err_o),
    .uart_tx    (uart_tx),
    .tx_empty_o (tx_empty_o)
  );

  always #5 clk_i = ~clk_i;

  // One strobe phase; response sampled one cycle after stb goes high
  task automatic wb(input logic [7:0] adr, input logic we, input logic [63:0] wd);
    @(posedge clk_i); #1;
    uart_adr_i = adr; uart_we_i = we; uart_dat_i = wd; uart_stb_i = 1'b1;
    @(posedge clk_i); #1;
    rd = uart_dat_o; ack = uart_ack_o; err = uart_err_o;
    uart_stb_i = 1'b0; uart_we_i = 1'b0;
  endtask

  // Waits (bounded) for the start bit, then records n cycles of the line
  task automatic capture(input int n);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk_i); #1;
      if (uart_tx === 1'b0) found = 1'b1;
    end
    if (found) begin
      samp[0] = uart_tx; emp[0] = tx_empty_o;
      for (int k = 1; k < n; k++) begin
        @(posedge clk_i); #1;
        samp[k] = uart_tx; emp[k] = tx_empty_o;
      end
    end
  endtask

  task automatic add_frame(input logic [7:0] d, input int nbits, input logic par_en,
                           input logic odd, input int nstop);
    logic p;
    p = odd;
    exp_bits[nexp] = 1'b0; nexp++;
    for (int i = 0; i < nbits; i++) begin
      exp_bits[nexp] = d[i]; p = p ^ d[i]; nexp++;
    end
    if (par_en) begin exp_bits[nexp] = p; nexp++; end
    for (int i = 0; i < nstop; i++) begin exp_bits[nexp] = 1'b1; nexp++; end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b expected 1", uart_tx); end
    checks++; if (uart_ack_o !== 1'b0 || uart_err_o !== 1'b0) begin errors++; $display("FAIL rst_ack_err: got %b%b expected 00", uart_ack_o, uart_err_o); end
    checks++; if (uart_dat_o !== 64'h0) begin errors++; $display("FAIL rst_dat: got %h expected 0", uart_dat_o); end
    checks++; if (tx_empty_o !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", tx_empty_o); end
    rst_ni = 1'b1;
    // tx_en=1, two_stop=0, odd=0, par_en=0, dbits=3, div=868 -> 0x230364
    wb(8'h08, 1'b0, '0);
    checks++; if (rd !== 64'h230364 || ack !== 1'b1) begin errors++; $display("FAIL ctrl_reset: got %h ack %b expected 230364 ack 1", rd, ack); end
    wb(8'h00, 1'b0, '0);
    checks++; if (rd !== 64'h4 || ack !== 1'b1) begin errors++; $display("FAIL stat_reset: got %h ack %b expected 4 ack 1", rd, ack); end
  endtask

  task automatic test_regs();
    wb(8'h18, 1'b0, '0);
    checks++; if (err !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL bad_read: got ack %b err %b expected ack 0 err 1", ack, err); end
    wb(8'h18, 1'b1, 64'h0);
    checks++; if (err !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL bad_write: got ack %b err %b expected ack 0 err 1", ack, err); end
    wb(8'h08, 1'b0, '0);
    checks++; if (rd !== 64'h230364) begin errors++; $display("FAIL ctrl_after_bad: got %h expected 230364", rd); end
    wb(8'h10, 1'b0, '0);
    checks++; if (rd !== 64'h0 || ack !== 1'b1) begin errors++; $display("FAIL data_read: got %h ack %b expected 0 ack 1", rd, ack); end
    @(posedge clk_i); #1;
    checks++; if (uart_ack_o !== 1'b0 || uart_err_o !== 1'b0) begin errors++; $display("FAIL ack_clear: got %b%b expected 00", uart_ack_o, uart_err_o); end
  endtask

  task automatic test_basic();
    wb(8'h08, 1'b1, 64'h230004);
    wb(8'h10, 1'b1, 64'h55);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_ack: got %b expected 1", ack); end
    capture(10 * DIV);
    checks++; if (!found) begin errors++; $display("FAIL basic_start: got no start bit expected one"); end
    nexp = 0; add_frame(8'h55, 8, 1'b0, 1'b0, 1);
    for (int b = 0; b < nexp; b++) begin
      logic [3:0] got;
      for (int j = 0; j < DIV; j++) got[j] = samp[b*DIV+j];
      checks++;
      if (got !== {4{exp_bits[b]}}) begin errors++; $display("FAIL basic_bit%0d: got %b expected %b", b, got, {4{exp_bits[b]}}); end
    end
    checks++; if (emp[0] !== 1'b0) begin errors++; $display("FAIL basic_busy: got tx_empty %b expected 0", emp[0]); end
    @(posedge clk_i); #1;
    checks++; if (tx_empty_o !== 1'b1 || uart_tx !== 1'b1) begin errors++; $display("FAIL basic_done: got empty %b tx %b expected 1 1", tx_empty_o, uart_tx); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] bytes [0:4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
    wb(8'h08, 1'b1, 64'h030004);
    for (int i = 0; i < 5; i++) begin
      wb(8'h10, 1'b1, {56'h0, bytes[i]});
      checks++;
      if (i < 4 && (ack !== 1'b1 || err !== 1'b0)) begin errors++; $display("FAIL push%0d: got ack %b err %b expected ack 1 err 0", i, ack, err); end
      else if (i == 4 && (ack !== 1'b0 || err !== 1'b1)) begin errors++; $display("FAIL push_full: got ack %b err %b expected ack 0 err 1", ack, err); end
    end
    // level 4, empty 0, full 1, busy 1 (FIFO non-empty)
    wb(8'h00, 1'b0, '0);
    checks++; if (rd !== 64'h0403) begin errors++; $display("FAIL stat_full: got %h expected 0403", rd); end
    wb(8'h08, 1'b1, 64'h230004);
    capture(40 * DIV);
    checks++; if (!found) begin errors++; $display("FAIL b2b_start: got no start bit expected one"); end
    nexp = 0;
    for (int i = 0; i < 4; i++) add_frame(bytes[i], 8, 1'b0, 1'b0, 1);
    for (int b = 0; b < nexp; b++) begin
      logic [3:0] got;
      for (int j = 0; j < DIV; j++) got[j] = samp[b*DIV+j];
      checks++;
      if (got !== {4{exp_bits[b]}}) begin errors++; $display("FAIL b2b_bit%0d: got %b expected %b", b, got, {4{exp_bits[b]}}); end
    end
    @(posedge clk_i); #1;
    checks++; if (tx_empty_o !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", tx_empty_o); end
  endtask

  task automatic test_format();
    // 7 data bits, even parity, two stop bits, divisor 4
    wb(8'h08, 1'b1, 64'h360004);
    wb(8'h10, 1'b1, 64'h03);
    capture(11 * DIV);
    checks++; if (!found) begin errors++; $display("FAIL fmt_start: got no start bit expected one"); end
    nexp = 0; add_frame(8'h03, 7, 1'b1, 1'b0, 2);
    for (int b = 0; b < nexp; b++) begin
      logic [3:0] got;
      for (int j = 0; j < DIV; j++) got[j] = samp[b*DIV+j];
      checks++;
      if (got !== {4{exp_bits[b]}}) begin errors++; $display("FAIL fmt_bit%0d: got %b expected %b", b, got, {4{exp_bits[b]}}); end
    end
    @(posedge clk_i); #1;
    checks++; if (tx_empty_o !== 1'b1) begin errors++; $display("FAIL fmt_done: got %b expected 1", tx_empty_o); end
  endtask

  task automatic test_odd_midframe();
    // 8 data bits, odd parity, one stop bit; switched to 8N1 during the frame
    wb(8'h08, 1'b1, 64'h2F0004);
    wb(8'h10, 1'b1, 64'h00);
    fork
      capture(21 * DIV);
      begin
        wb(8'h10, 1'b1, 64'hA5);
        wb(8'h08, 1'b1, 64'h230004);
      end
    join
    checks++; if (!found) begin errors++; $display("FAIL mid_start: got no start bit expected one"); end
    nexp = 0;
    add_frame(8'h00, 8, 1'b1, 1'b1, 1);
    add_frame(8'hA5, 8, 1'b0, 1'b0, 1);
    for (int b = 0; b < nexp; b++) begin
      logic [3:0] got;
      for (int j = 0; j < DIV; j++) got[j] = samp[b*DIV+j];
      checks++;
      if (got !== {4{exp_bits[b]}}) begin errors++; $display("FAIL mid_bit%0d: got %b expected %b", b, got, {4{exp_bits[b]}}); end
    end
    wb(8'h08, 1'b0, '0);
    checks++; if (rd !== 64'h230004) begin errors++; $display("FAIL mid_ctrl: got %h expected 230004", rd); end
  endtask

  task automatic test_reset_midframe();
    int highs;
    wb(8'h10, 1'b1, 64'h00);
    wb(8'h10, 1'b1, 64'h00);
    capture(8);
    checks++; if (!found || samp[7] !== 1'b0) begin errors++; $display("FAIL rstmid_low: got found %b tx %b expected found 1 tx 0", found, samp[7]); end
    #3 rst_ni = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b expected 1", uart_tx); end
    checks++; if (tx_empty_o !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b expected 1", tx_empty_o); end
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    wb(8'h00, 1'b0, '0);
    checks++; if (rd !== 64'h0004) begin errors++; $display("FAIL rstmid_stat: got %h expected 0004", rd); end
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      if (uart_tx === 1'b1) highs++;
    end
    checks++; if (highs != 20) begin errors++; $display("FAIL rstmid_idle: got %0d high cycles expected 20", highs); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_basic();
    test_fifo_full();
    test_format();
    test_odd_midframe();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
